wave_param_loader: RTL

Collects 16-bit amplitude, offset and phase-word streams from three host pipe endpoints into per-channel shadow banks. On a host commit request, it transfers the shadow banks atomically into the active banks that drive the 64-channel synthesis block. After the transfer it pulses a phase-realignment reset so all channels restart coherently. It replaces free-running block-address loading with a counted, atomic load/commit sequence and exposes a status word for a wire-out endpoint.

---
 rtl/wave_param_loader_if.sv | 35 +++
 rtl/wave_param_loader.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/wave_param_loader_if.sv
// Host-side bundle of the parameter loader: three word streams plus control in,
// active banks and status out.
interface wave_param_loader_if #(
  parameter int NCH = 64,
  parameter int W   = 16
);
  logic             amp_write;
  logic [W-1:0]     amp_data;
  logic             offset_write;
  logic [W-1:0]     offset_data;
  logic             phaseword_write;
  logic [W-1:0]     phaseword_data;
  logic             commit_req;
  logic             abort;
  logic             clear_flags;
  logic [NCH*W-1:0] amps;
  logic [NCH*W-1:0] offsets;
  logic [NCH*W-1:0] phasewords;
  logic             phase_reset;
  logic             loaded;
  logic             commit_done;
  logic [15:0]      status;

  modport master (
    output amp_write, amp_data, offset_write, offset_data,
           phaseword_write, phaseword_data, commit_req, abort, clear_flags,
    input  amps, offsets, phasewords, phase_reset, loaded, commit_done, status
  );

  modport slave (
    input  amp_write, amp_data, offset_write, offset_data,
           phaseword_write, phaseword_data, commit_req, abort, clear_flags,
    output amps, offsets, phasewords, phase_reset, loaded, commit_done, status
  );
endinterface

// File: rtl/wave_param_loader.sv
// Counted shadow-bank loader with atomic commit into the active banks and a
// post-commit phase-realignment pulse for the synthesis block.
module wave_param_loader_stream #(
  parameter int NCH = 64,
  parameter int W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load_ok,
  input  logic             i_clear,
  input  logic             i_ovf_en,
  input  logic             i_write,
  input  logic [W-1:0]     i_data,
  output logic [NCH*W-1:0] o_shadow,
  output logic             o_full_next,
  output logic             o_ovf
);
  localparam int CW = $clog2(NCH + 1);
  localparam int AW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [CW-1:0]           r_cnt;
  logic [NCH-1:0][W-1:0]   r_shadow;
  logic                    w_full;
  logic                    w_store;

  assign w_full      = (r_cnt == CW'(NCH));
  assign w_store     = i_write && i_load_ok && !w_full;
  assign o_ovf       = i_write && i_ovf_en && !w_store;
  // Lets the top enter READY in the cycle right after the last word lands.
  assign o_full_next = w_full || (w_store && (r_cnt == CW'(NCH - 1)));
  assign o_shadow    = r_shadow;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_shadow <= '0;
    end else begin
      if (i_clear)      r_cnt <= '0;
      else if (w_store) r_cnt <= r_cnt + 1'b1;
      if (w_store) r_shadow[r_cnt[AW-1:0]] <= i_data;
    end
  end
endmodule

module wave_param_loader #(
  parameter int NCH         = 64,
  parameter int W           = 16,
  parameter int SYNC_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  wave_param_loader_if.slave  bus
);
  localparam int BW = NCH * W;
  localparam int HW = $clog2(SYNC_CYCLES + 1);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_READY  = 2'd1,
    S_COMMIT = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t                 r_state, w_next;
  logic [HW-1:0]          r_hold;
  logic [2:0]             w_wr, w_full_next, w_ovf;
  logic [2:0][W-1:0]      w_data;
  logic [2:0][BW-1:0]     w_shadow;
  logic [2:0][BW-1:0]     r_active;
  logic                   w_abort, w_load_ok, w_clear, w_ovf_set, w_cerr_set;
  logic                   r_loaded, r_ovf, r_cerr, r_commit_done, r_phase_reset;
  logic [7:0]             r_ccount;

  // Stream index: 0 = amplitude, 1 = offset, 2 = phase word.
  assign w_wr   = {bus.phaseword_write, bus.offset_write, bus.amp_write};
  assign w_data = {bus.phaseword_data, bus.offset_data, bus.amp_data};

  // Abort only has effect while loading or armed; strobes in that cycle vanish silently.
  assign w_abort    = bus.abort && ((r_state == S_LOAD) || (r_state == S_READY));
  assign w_load_ok  = (r_state == S_LOAD) && !w_abort;
  assign w_clear    = w_abort || (r_state == S_COMMIT);
  assign w_ovf_set  = |w_ovf;
  assign w_cerr_set = bus.commit_req && (r_state == S_LOAD);

  for (genvar g = 0; g < 3; g++) begin : g_stream
    wave_param_loader_stream #(.NCH(NCH), .W(W)) u_stream (
      .clk         (clk),
      .reset       (reset),
      .i_load_ok   (w_load_ok),
      .i_clear     (w_clear),
      .i_ovf_en    (!w_abort),
      .i_write     (w_wr[g]),
      .i_data      (w_data[g]),
      .o_shadow    (w_shadow[g]),
      .o_full_next (w_full_next[g]),
      .o_ovf       (w_ovf[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_LOAD;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD:   if (!w_abort && (&w_full_next)) w_next = S_READY;
      S_READY:  if (w_abort)             w_next = S_LOAD;
                else if (bus.commit_req) w_next = S_COMMIT;
      S_COMMIT: w_next = S_HOLD;
      S_HOLD:   if (r_hold == HW'(SYNC_CYCLES - 1)) w_next = S_LOAD;
      default:  w_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold        <= '0;
      r_loaded      <= 1'b0;
      r_commit_done <= 1'b0;
      r_phase_reset <= 1'b0;
      r_active      <= '0;
      r_ccount      <= '0;
      r_ovf         <= 1'b0;
      r_cerr        <= 1'b0;
    end else begin
      r_hold        <= (r_state == S_HOLD) ? r_hold + 1'b1 : '0;
      // Status outputs track the state they describe, so they are registered from w_next.
      r_loaded      <= (w_next == S_READY);
      r_commit_done <= (w_next == S_COMMIT);
      r_phase_reset <= (w_next == S_COMMIT) || (w_next == S_HOLD);
      if (r_state == S_COMMIT) begin
        r_active <= w_shadow;
        r_ccount <= r_ccount + 8'd1;
      end
      if (w_ovf_set)            r_ovf <= 1'b1;
      else if (bus.clear_flags) r_ovf <= 1'b0;
      if (w_cerr_set)           r_cerr <= 1'b1;
      else if (bus.clear_flags) r_cerr <= 1'b0;
    end
  end

  assign bus.amps        = r_active[0];
  assign bus.offsets     = r_active[1];
  assign bus.phasewords  = r_active[2];
  assign bus.phase_reset = r_phase_reset;
  assign bus.loaded      = r_loaded;
  assign bus.commit_done = r_commit_done;
  assign bus.status      = {r_loaded, r_ovf, r_cerr, r_state, 3'b000, r_ccount};
endmodule
